// File: rtl/ptw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ptw_pkg
// Description : Shared types and constants for the page-table-walk AXI port:
//               FSM state encoding, TLB source indices and AXI4 field values.
// Revision    : 1.0 - initial release
// ============================================================================
package ptw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } ptw_state_t;

    localparam logic SRC_ITLB = 1'b0;
    localparam logic SRC_DTLB = 1'b1;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_8B     = 3'b011;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [2:0] PROT_PTW    = 3'b001;

    // Both slave and decode errors are reported to the TLB as a fault.
    function automatic logic is_err_resp(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ptw_arbiter
// Description : 2-way grant between ITLB and DTLB walk requests.
//               Macro PTW_RR_ARB_EN: round-robin with a turn pointer;
//               otherwise fixed priority ITLB over DTLB (no pointer).
// Revision    : 1.0 - initial release
// ============================================================================
module ptw_arbiter
    import ptw_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_valid,
    output logic       grant_src
);

    assign grant_valid = |req;

`ifdef PTW_RR_ARB_EN
    logic ptr;

    // Turn pointer hands priority to the loser whenever both sources competed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= SRC_ITLB;
        end else if (advance && (req == 2'b11)) begin
            ptr <= ~grant_src;
        end
    end

    // Pointer decides only under contention; a lone requester always wins.
    always_comb begin
        grant_src = SRC_ITLB;
        if (req == 2'b11) begin
            grant_src = ptr;
        end else if (req[SRC_DTLB]) begin
            grant_src = SRC_DTLB;
        end
    end
`else
    logic unused_arb;
    assign unused_arb = ^{CLK, RST, advance};

    // Fixed priority: ITLB wins whenever it is requesting.
    always_comb begin
        grant_src = SRC_ITLB;
        if (!req[SRC_ITLB] && req[SRC_DTLB]) begin
            grant_src = SRC_DTLB;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/ptw_axi_master.sv
`default_nettype none
// ============================================================================
// Module      : ptw_axi_master
// Description : Page-table-walk AXI4 read port shared by ITLB and DTLB.
//               Captures fetch pulses, arbitrates, issues one single-beat
//               64-bit read at a time and returns the PTE as a one-cycle pulse.
//               Macro PTW_RR_ARB_EN selects round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module ptw_axi_master
    import ptw_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic                  ITLB_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] ITLB_REQ_ADDR,
    output logic                  ITLB_RESP_VALID,
    output logic [DATA_WIDTH-1:0] ITLB_RESP_DATA,
    output logic                  ITLB_RESP_ERR,
    input  logic                  DTLB_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] DTLB_REQ_ADDR,
    output logic                  DTLB_RESP_VALID,
    output logic [DATA_WIDTH-1:0] DTLB_RESP_DATA,
    output logic                  DTLB_RESP_ERR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    output logic [ADDR_WIDTH-1:0] M_ARADDR,
    output logic [7:0]            M_ARLEN,
    output logic [2:0]            M_ARSIZE,
    output logic [1:0]            M_ARBURST,
    output logic [2:0]            M_ARPROT,
    input  logic                  M_RVALID,
    output logic                  M_RREADY,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RLAST
);

    ptw_state_t            state;
    ptw_state_t            next_state;
    logic [1:0]            pending;
    logic [ADDR_WIDTH-1:0] itlb_addr;
    logic [ADDR_WIDTH-1:0] dtlb_addr;
    logic                  owner;
    logic                  drop;
    logic [DATA_WIDTH-1:0] resp_data;

    logic [1:0]            busy;
    logic [1:0]            capture;
    logic [1:0]            eligible;
    logic [1:0]            grant_mask;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  grant_valid;
    logic                  grant_src;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  issue;
    logic                  deliver;
    logic                  unused_rlast;

    assign unused_rlast = M_RLAST;

    assign M_ARLEN   = 8'd0;
    assign M_ARSIZE  = SIZE_8B;
    assign M_ARBURST = BURST_INCR;
    assign M_ARPROT  = PROT_PTW;

    // A source with a transaction in AR or R may not post another request.
    assign busy[SRC_ITLB] = (state != ST_IDLE) && (owner == SRC_ITLB);
    assign busy[SRC_DTLB] = (state != ST_IDLE) && (owner == SRC_DTLB);
    assign capture  = {DTLB_REQ_VALID, ITLB_REQ_VALID} & ~pending & ~busy & {2{~FLUSH}};
    // Same-cycle requests join arbitration so ARVALID can rise the next cycle.
    assign eligible = pending | capture;

    assign issue_addr = (grant_src == SRC_DTLB)
                      ? (capture[SRC_DTLB] ? DTLB_REQ_ADDR : dtlb_addr)
                      : (capture[SRC_ITLB] ? ITLB_REQ_ADDR : itlb_addr);

    assign ar_hs   = (state == ST_AR) && M_ARREADY;
    assign r_hs    = (state == ST_R) && M_RVALID;
    // Issue from IDLE or straight out of the R handshake for back-to-back reads.
    assign issue   = grant_valid && !FLUSH && ((state == ST_IDLE) || r_hs);
    assign deliver = r_hs && !drop && !FLUSH;
    assign grant_mask = issue ? ((grant_src == SRC_DTLB) ? 2'b10 : 2'b01) : 2'b00;

    ptw_arbiter u_arbiter (
        .CLK         (CLK),
        .RST         (RST),
        .req         (eligible),
        .advance     (issue),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode for the AR / R sequence.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (issue) next_state = ST_AR;
            ST_AR:   if (ar_hs) next_state = ST_R;
            ST_R:    if (r_hs)  next_state = issue ? ST_AR : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Per-source pending bits and latched PTE addresses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending   <= 2'b00;
            itlb_addr <= '0;
            dtlb_addr <= '0;
        end else begin
            pending <= FLUSH ? 2'b00 : (eligible & ~grant_mask);
            if (capture[SRC_ITLB]) itlb_addr <= ITLB_REQ_ADDR;
            if (capture[SRC_DTLB]) dtlb_addr <= DTLB_REQ_ADDR;
        end
    end

    // AXI address/read channel handshakes, owner and flush-drop tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            M_ARVALID <= 1'b0;
            M_ARADDR  <= '0;
            M_RREADY  <= 1'b0;
            owner     <= SRC_ITLB;
            drop      <= 1'b0;
        end else begin
            if (issue) begin
                M_ARVALID <= 1'b1;
                M_ARADDR  <= {issue_addr[ADDR_WIDTH-1:3], 3'b000};
                owner     <= grant_src;
            end else if (ar_hs) begin
                M_ARVALID <= 1'b0;
            end
            if (ar_hs) begin
                M_RREADY <= 1'b1;
            end else if (r_hs) begin
                M_RREADY <= 1'b0;
            end
            // A flushed transaction still completes on AXI; only its result is dropped.
            if (r_hs) begin
                drop <= 1'b0;
            end else if (FLUSH && (state != ST_IDLE)) begin
                drop <= 1'b1;
            end
        end
    end

    // Registered one-cycle response pulse to the owning TLB.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ITLB_RESP_VALID <= 1'b0;
            ITLB_RESP_ERR   <= 1'b0;
            DTLB_RESP_VALID <= 1'b0;
            DTLB_RESP_ERR   <= 1'b0;
            resp_data       <= '0;
        end else begin
            ITLB_RESP_VALID <= deliver && (owner == SRC_ITLB);
            ITLB_RESP_ERR   <= deliver && (owner == SRC_ITLB) && is_err_resp(M_RRESP);
            DTLB_RESP_VALID <= deliver && (owner == SRC_DTLB);
            DTLB_RESP_ERR   <= deliver && (owner == SRC_DTLB) && is_err_resp(M_RRESP);
            if (deliver) resp_data <= M_RDATA;
        end
    end

    assign ITLB_RESP_DATA = resp_data;
    assign DTLB_RESP_DATA = resp_data;

endmodule
`default_nettype wire

// File: tb/tb_ptw_axi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ptw_axi_master
// Description : Self-checking bench for ptw_axi_master with a scripted AXI
//               read slave and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ptw_axi_master;

    logic        CLK = 1'b0;
    logic        RST, FLUSH;
    logic        ITLB_REQ_VALID, DTLB_REQ_VALID;
    logic [63:0] ITLB_REQ_ADDR, DTLB_REQ_ADDR;
    logic        ITLB_RESP_VALID, DTLB_RESP_VALID, ITLB_RESP_ERR, DTLB_RESP_ERR;
    logic [63:0] ITLB_RESP_DATA, DTLB_RESP_DATA;
    logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY, M_RLAST;
    logic [63:0] M_ARADDR, M_RDATA;
    logic [7:0]  M_ARLEN;
    logic [2:0]  M_ARSIZE, M_ARPROT;
    logic [1:0]  M_ARBURST, M_RRESP;

    always #5 CLK = ~CLK;

    ptw_axi_master dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .ITLB_REQ_VALID(ITLB_REQ_VALID), .ITLB_REQ_ADDR(ITLB_REQ_ADDR),
        .ITLB_RESP_VALID(ITLB_RESP_VALID), .ITLB_RESP_DATA(ITLB_RESP_DATA), .ITLB_RESP_ERR(ITLB_RESP_ERR),
        .DTLB_REQ_VALID(DTLB_REQ_VALID), .DTLB_REQ_ADDR(DTLB_REQ_ADDR),
        .DTLB_RESP_VALID(DTLB_RESP_VALID), .DTLB_RESP_DATA(DTLB_RESP_DATA), .DTLB_RESP_ERR(DTLB_RESP_ERR),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
        .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARPROT(M_ARPROT),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA),
        .M_RRESP(M_RRESP), .M_RLAST(M_RLAST)
    );

    typedef struct {
        logic        src;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          resp_count = 0;

    // Scripted slave controls and observations
    int          ar_delay = 0;
    int          r_delay = 0;
    logic [1:0]  slave_rresp = 2'b00;
    int          ar_hs_count = 0;
    int          r_hs_count = 0;
    logic [63:0] ar_log[$];

    function automatic logic [63:0] pte_for(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_1230) return 64'h0000_0000_2000_00CF;
        return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0] + 32'h0000_0011};
    endfunction

    task automatic push_exp(input logic src, input logic [63:0] addr, input logic err);
        exp_t e;
        e.src  = src;
        e.data = pte_for({addr[63:3], 3'b000});
        e.err  = err;
        sb.push_back(e);
    endtask

    // Drive one request cycle (called just after a rising edge)
    task automatic drive_req(input logic iv, input logic [63:0] ia, input logic dv, input logic [63:0] da);
        ITLB_REQ_VALID = iv; ITLB_REQ_ADDR = ia;
        DTLB_REQ_VALID = dv; DTLB_REQ_ADDR = da;
        @(posedge CLK); #1;
        ITLB_REQ_VALID = 1'b0; DTLB_REQ_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || M_ARVALID || M_RREADY) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_idle: timeout with %0d responses outstanding, expected 0", name, sb.size());
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    // AXI read slave: programmable AR stall and R latency, acts 2ns after each edge
    initial begin
        logic        s_hs_ar, s_hs_r;
        logic [63:0] s_addr, s_raddr;
        int          s_phase, s_cnt;
        M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = 2'b00; M_RLAST = 1'b0;
        s_phase = 0; s_cnt = 0; s_raddr = '0;
        forever begin
            @(negedge CLK);
            s_hs_ar = M_ARVALID && M_ARREADY;
            s_hs_r  = M_RVALID && M_RREADY;
            s_addr  = M_ARADDR;
            @(posedge CLK); #2;
            if (RST) begin
                M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RLAST = 1'b0; s_phase = 0; s_cnt = 0;
            end else begin
                if (s_hs_r) begin
                    M_RVALID = 1'b0; M_RLAST = 1'b0; r_hs_count++; s_phase = 0; s_cnt = 0;
                end
                if (s_hs_ar) begin
                    M_ARREADY = 1'b0; ar_hs_count++; ar_log.push_back(s_addr);
                    s_phase = 1; s_cnt = 0; s_raddr = s_addr;
                end
                if (s_phase == 1) begin
                    if (s_cnt >= r_delay) begin
                        M_RVALID = 1'b1; M_RLAST = 1'b1; M_RDATA = pte_for(s_raddr);
                        M_RRESP = slave_rresp; s_phase = 2;
                    end else begin
                        s_cnt++;
                    end
                end else if (s_phase == 0 && M_ARVALID && !M_ARREADY) begin
                    if (s_cnt >= ar_delay) M_ARREADY = 1'b1;
                    else s_cnt++;
                end
            end
        end
    end

    // Response monitor: every RESP_VALID pulse must match the scoreboard head
    initial begin
        logic        got_src, got_err;
        logic [63:0] got_data;
        forever begin
            @(negedge CLK);
            if (ITLB_RESP_VALID === 1'b1 || DTLB_RESP_VALID === 1'b1) begin
                resp_count++;
                checks++;
                if (ITLB_RESP_VALID && DTLB_RESP_VALID) begin
                    errors++;
                    $display("FAIL resp_both: itlb_v=1 dtlb_v=1, expected a single owner");
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: itlb_v=%b dtlb_v=%b data=%h, expected no response",
                             ITLB_RESP_VALID, DTLB_RESP_VALID, ITLB_RESP_DATA);
                end else begin
                    mon_e    = sb.pop_front();
                    got_src  = DTLB_RESP_VALID;
                    got_data = got_src ? DTLB_RESP_DATA : ITLB_RESP_DATA;
                    got_err  = got_src ? DTLB_RESP_ERR : ITLB_RESP_ERR;
                    if (got_src !== mon_e.src || got_data !== mon_e.data || got_err !== mon_e.err) begin
                        errors++;
                        $display("FAIL resp_scoreboard: got src=%0d data=%h err=%b, expected src=%0d data=%h err=%b",
                                 got_src, got_data, got_err, mon_e.src, mon_e.data, mon_e.err);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        RST = 1'b1; FLUSH = 1'b0;
        ITLB_REQ_VALID = 1'b0; DTLB_REQ_VALID = 1'b0; ITLB_REQ_ADDR = '0; DTLB_REQ_ADDR = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({M_ARVALID, M_RREADY, ITLB_RESP_VALID, DTLB_RESP_VALID, ITLB_RESP_ERR, DTLB_RESP_ERR} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: arv/rrdy/iv/dv/ie/de=%b, expected 000000",
                     {M_ARVALID, M_RREADY, ITLB_RESP_VALID, DTLB_RESP_VALID, ITLB_RESP_ERR, DTLB_RESP_ERR});
        end
        checks++;
        if (M_ARADDR !== 64'd0 || ITLB_RESP_DATA !== 64'd0 || DTLB_RESP_DATA !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: araddr=%h idata=%h ddata=%h, expected all 0", M_ARADDR, ITLB_RESP_DATA, DTLB_RESP_DATA);
        end
        checks++;
        if ({M_ARLEN, M_ARSIZE, M_ARBURST, M_ARPROT} !== {8'd0, 3'b011, 2'b01, 3'b001}) begin
            errors++;
            $display("FAIL ar_consts: len=%h size=%b burst=%b prot=%b, expected 00 011 01 001",
                     M_ARLEN, M_ARSIZE, M_ARBURST, M_ARPROT);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_single();
        push_exp(1'b0, 64'h8000_1234, 1'b0);
        drive_req(1'b1, 64'h8000_1234, 1'b0, '0);
        @(negedge CLK);
        checks++;
        if (M_ARVALID !== 1'b1 || M_ARADDR !== 64'h8000_1230) begin
            errors++;
            $display("FAIL single_ar: arvalid=%b araddr=%h, expected 1 0000000080001230", M_ARVALID, M_ARADDR);
        end
        @(negedge CLK);
        checks++;
        if (ITLB_RESP_VALID !== 1'b0 || M_RREADY !== 1'b1) begin
            errors++;
            $display("FAIL single_r: resp_valid=%b rready=%b, expected 0 1", ITLB_RESP_VALID, M_RREADY);
        end
        @(negedge CLK);
        checks++;
        if (ITLB_RESP_VALID !== 1'b1 || ITLB_RESP_DATA !== 64'h2000_00CF || ITLB_RESP_ERR !== 1'b0 || DTLB_RESP_VALID !== 1'b0) begin
            errors++;
            $display("FAIL single_resp: iv=%b data=%h err=%b dv=%b, expected 1 00000000200000cf 0 0",
                     ITLB_RESP_VALID, ITLB_RESP_DATA, ITLB_RESP_ERR, DTLB_RESP_VALID);
        end
        @(negedge CLK);
        checks++;
        if (ITLB_RESP_VALID !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: resp_valid=%b one cycle later, expected 0", ITLB_RESP_VALID);
        end
        wait_idle("single");
    endtask

    // Simultaneous pairs, including the back-to-back AR after the first R beat
    task automatic test_arb_pair();
        int          base, n;
        logic        dtlb_first;
        logic [63:0] first_addr, second_addr;
        base = ar_log.size();
        push_exp(1'b0, 64'h1000, 1'b0);
        push_exp(1'b1, 64'h2000, 1'b0);
        drive_req(1'b1, 64'h1000, 1'b1, 64'h2000);
        n = 0;
        while (!(M_RVALID && M_RREADY) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        checks++;
        if (M_ARVALID !== 1'b1 || M_ARADDR !== 64'h2000) begin
            errors++;
            $display("FAIL back_to_back: arvalid=%b araddr=%h after R beat, expected 1 0000000000002000", M_ARVALID, M_ARADDR);
        end
        wait_idle("pair1");
        checks++;
        if (ar_log.size() != base + 2 || ar_log[base] !== 64'h1000 || ar_log[base+1] !== 64'h2000) begin
            errors++;
            $display("FAIL pair1_order: %0d ARs, first=%h, expected 2 ARs 1000 then 2000",
                     ar_log.size() - base, (ar_log.size() > base) ? ar_log[base] : 64'hX);
        end
`ifdef PTW_RR_ARB_EN
        dtlb_first = 1'b1;
`else
        dtlb_first = 1'b0;
`endif
        first_addr  = dtlb_first ? 64'h2000 : 64'h1000;
        second_addr = dtlb_first ? 64'h1000 : 64'h2000;
        base = ar_log.size();
        push_exp(dtlb_first, first_addr, 1'b0);
        push_exp(~dtlb_first, second_addr, 1'b0);
        drive_req(1'b1, 64'h1000, 1'b1, 64'h2000);
        wait_idle("pair2");
        checks++;
        if (ar_log.size() != base + 2 || ar_log[base] !== first_addr || ar_log[base+1] !== second_addr) begin
            errors++;
            $display("FAIL pair2_order: %0d ARs, first=%h, expected 2 ARs %h then %h",
                     ar_log.size() - base, (ar_log.size() > base) ? ar_log[base] : 64'hX, first_addr, second_addr);
        end
    endtask

    task automatic test_arready_stall();
        int hs0;
        hs0 = ar_hs_count;
        ar_delay = 5;
        push_exp(1'b1, 64'h3008, 1'b0);
        drive_req(1'b0, '0, 1'b1, 64'h3008);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            checks++;
            if (M_ARVALID !== 1'b1 || M_ARADDR !== 64'h3008) begin
                errors++;
                $display("FAIL stall_stable[%0d]: arvalid=%b araddr=%h, expected 1 0000000000003008", i, M_ARVALID, M_ARADDR);
            end
        end
        wait_idle("stall");
        ar_delay = 0;
        checks++;
        if (ar_hs_count - hs0 != 1) begin
            errors++;
            $display("FAIL stall_hs_count: %0d AR handshakes, expected 1", ar_hs_count - hs0);
        end
    endtask

    task automatic test_err_resp();
        slave_rresp = 2'b11;
        push_exp(1'b1, 64'h4000, 1'b1);
        drive_req(1'b0, '0, 1'b1, 64'h4000);
        wait_idle("decerr");
        slave_rresp = 2'b10;
        push_exp(1'b0, 64'h4100, 1'b1);
        drive_req(1'b1, 64'h4100, 1'b0, '0);
        wait_idle("slverr");
        slave_rresp = 2'b00;
    endtask

    task automatic test_flush_ar();
        int hs0, rh0, rc0;
        hs0 = ar_hs_count; rh0 = r_hs_count; rc0 = resp_count;
        ar_delay = 4;
        drive_req(1'b1, 64'h5000, 1'b0, '0);
        FLUSH = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (M_ARVALID !== 1'b1) begin
                errors++;
                $display("FAIL flush_arvalid[%0d]: arvalid=%b, expected 1 until handshake", i, M_ARVALID);
            end
            @(posedge CLK); #1;
            FLUSH = 1'b0;
        end
        wait_idle("flush");
        ar_delay = 0;
        checks++;
        if (ar_hs_count - hs0 != 1 || r_hs_count - rh0 != 1) begin
            errors++;
            $display("FAIL flush_axi: ar_hs=%0d r_hs=%0d, expected 1 1", ar_hs_count - hs0, r_hs_count - rh0);
        end
        checks++;
        if (resp_count != rc0) begin
            errors++;
            $display("FAIL flush_no_resp: %0d responses, expected 0", resp_count - rc0);
        end
        push_exp(1'b0, 64'h6000, 1'b0);
        drive_req(1'b1, 64'h6000, 1'b0, '0);
        wait_idle("after_flush");
    endtask

    task automatic test_req_on_resp();
        push_exp(1'b0, 64'h9000, 1'b0);
        drive_req(1'b1, 64'h9000, 1'b0, '0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        push_exp(1'b0, 64'h9100, 1'b0);
        ITLB_REQ_VALID = 1'b1; ITLB_REQ_ADDR = 64'h9100;
        @(negedge CLK);
        checks++;
        if (ITLB_RESP_VALID !== 1'b1) begin
            errors++;
            $display("FAIL req_on_resp_align: resp_valid=%b, expected 1 alongside new request", ITLB_RESP_VALID);
        end
        @(posedge CLK); #1;
        ITLB_REQ_VALID = 1'b0;
        wait_idle("req_on_resp");
    endtask

    task automatic test_reset_in_r();
        int   n;
        logic saw_ar;
        r_delay = 6;
        drive_req(1'b0, '0, 1'b1, 64'h7000);
        drive_req(1'b1, 64'h7100, 1'b0, '0);
        n = 0;
        while (M_RREADY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({M_ARVALID, M_RREADY, ITLB_RESP_VALID, DTLB_RESP_VALID} !== 4'b0) begin
            errors++;
            $display("FAIL rst_in_r: arv/rrdy/iv/dv=%b, expected 0000",
                     {M_ARVALID, M_RREADY, ITLB_RESP_VALID, DTLB_RESP_VALID});
        end
        r_delay = 0;
        saw_ar = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (M_ARVALID === 1'b1) saw_ar = 1'b1;
        end
        checks++;
        if (saw_ar !== 1'b0) begin
            errors++;
            $display("FAIL rst_pending: arvalid=1 after reset, expected pending cleared");
        end
        @(posedge CLK); #1;
        push_exp(1'b0, 64'hA000, 1'b0);
        drive_req(1'b1, 64'hA000, 1'b0, '0);
        wait_idle("after_rst");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_arb_pair();
        test_arready_stall();
        test_err_resp();
        test_flush_ar();
        test_req_on_resp();
        test_reset_in_r();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses missing, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
